// File: rtl/st_packet_fifo.sv
// Avalon-ST packet FIFO with first-word fall-through, optional store-and-forward
// release, input framing check, and fill/packet counters.
module st_packet_fifo #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DEPTH         = 16,
   parameter int unsigned STORE_FORWARD = 0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic                         in_sop,
   input  logic                         in_eop,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_sop,
   output logic                         out_eop,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [$clog2(DEPTH+1)-1:0]   pkt_count,
   output logic                         proto_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = $clog2(DEPTH+1);
   localparam int unsigned EW = DATA_WIDTH + 2;

   // Entry layout: {sop, eop, data}
   logic [EW-1:0]  mem_q [DEPTH];
   logic [EW-1:0]  head;

   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  level_q, level_d;
   logic [CW-1:0]  pkt_q, pkt_d;
   logic           in_ready_q, in_ready_d;
   logic           out_valid_q, out_valid_d;
   logic           perr_q, perr_d;
   logic           in_pkt_q, in_pkt_d;
   logic           wr_en, rd_en, wr_eop, rd_eop;
   logic           empty_d, full_d;

   assign head = mem_q[rd_ptr_q[AW-1:0]];

   // Next-state: pointers, counters, flags and handshake outputs
   always_comb begin
      wr_en       = in_valid && in_ready_q;
      rd_en       = out_valid_q && out_ready;
      wr_eop      = wr_en && in_eop;
      rd_eop      = rd_en && head[EW-2];
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      pkt_d       = pkt_q;
      in_pkt_d    = in_pkt_q;
      perr_d      = 1'b0;

      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);

      case ({wr_en, rd_en})
         2'b10:   level_d = level_q + CW'(1);
         2'b01:   level_d = level_q - CW'(1);
         default: level_d = level_q;
      endcase

      case ({wr_eop, rd_eop})
         2'b10:   pkt_d = pkt_q + CW'(1);
         2'b01:   pkt_d = pkt_q - CW'(1);
         default: pkt_d = pkt_q;
      endcase

      // Framing: sop inside a packet, or a non-sop beat outside one
      if (wr_en) begin
         perr_d = (in_sop && in_pkt_q) || (!in_sop && !in_pkt_q);
         if (in_eop)      in_pkt_d = 1'b0;
         else if (in_sop) in_pkt_d = 1'b1;
      end

      empty_d    = (wr_ptr_d == rd_ptr_d);
      full_d     = (wr_ptr_d[PW-1] != rd_ptr_d[PW-1]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      in_ready_d = !full_d;
      // Full term lets packets longer than the FIFO flow cut-through
      out_valid_d = !empty_d &&
                    ((STORE_FORWARD == 0) || (pkt_d != '0) || full_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         pkt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         perr_q      <= 1'b0;
         in_pkt_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         pkt_q       <= pkt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         perr_q      <= perr_d;
         in_pkt_q    <= in_pkt_d;
      end
   end

   // Storage needs no reset; validity is tracked by the pointers
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= {in_sop, in_eop, in_data};
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sop   = head[EW-1];
   assign out_eop   = head[EW-2];
   assign out_data  = head[DATA_WIDTH-1:0];
   assign level     = level_q;
   assign pkt_count = pkt_q;
   assign proto_err = perr_q;

endmodule

// File: tb/tb_st_packet_fifo.sv
// Directed + randomized bench for st_packet_fifo: one cut-through and one
// store-and-forward instance, each with a queue scoreboard of accepted beats.
module tb_st_packet_fifo;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CW    = $clog2(DEPTH+1);

   typedef logic [DW+1:0] beat_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   logic          c_in_valid, c_in_ready, c_in_sop, c_in_eop;
   logic [DW-1:0] c_in_data, c_out_data;
   logic          c_out_valid, c_out_ready, c_out_sop, c_out_eop, c_perr;
   logic [CW-1:0] c_level, c_pkt;

   logic          s_in_valid, s_in_ready, s_in_sop, s_in_eop;
   logic [DW-1:0] s_in_data, s_out_data;
   logic          s_out_valid, s_out_ready, s_out_sop, s_out_eop, s_perr;
   logic [CW-1:0] s_level, s_pkt;

   st_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_FORWARD(0)) dut_ct (
      .clk(clk), .reset_n(reset_n),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sop(c_in_sop),
      .in_eop(c_in_eop), .in_data(c_in_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_sop(c_out_sop),
      .out_eop(c_out_eop), .out_data(c_out_data),
      .level(c_level), .pkt_count(c_pkt), .proto_err(c_perr));

   st_packet_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .STORE_FORWARD(1)) dut_sf (
      .clk(clk), .reset_n(reset_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_sop(s_in_sop),
      .in_eop(s_in_eop), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sop(s_out_sop),
      .out_eop(s_out_eop), .out_data(s_out_data),
      .level(s_level), .pkt_count(s_pkt), .proto_err(s_perr));

   int    checks = 0;
   int    errors = 0;
   beat_t qc[$];
   beat_t qs[$];
   int    perr_c = 0;
   int    perr_s = 0;
   int    s_pops = 0;
   int    max_s_level = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int eop_count();
      int n = 0;
      foreach (qc[i]) if (qc[i][DW]) n++;
      return n;
   endfunction

   // Scoreboard the handshakes about to happen, then advance one cycle
   task automatic tick();
      beat_t e;
      if (c_in_valid && c_in_ready) qc.push_back({c_in_sop, c_in_eop, c_in_data});
      if (s_in_valid && s_in_ready) qs.push_back({s_in_sop, s_in_eop, s_in_data});
      if (c_out_valid && c_out_ready) begin
         checks++;
         assert (qc.size() != 0) else begin
            errors++;
            $error("FAIL c_unexpected_beat: observed 0x%0h expected none", c_out_data);
         end
         if (qc.size() != 0) begin
            e = qc.pop_front();
            chk("c_beat", 64'({c_out_sop, c_out_eop, c_out_data}), 64'(e));
         end
      end
      if (s_out_valid && s_out_ready) begin
         checks++;
         assert (qs.size() != 0) else begin
            errors++;
            $error("FAIL s_unexpected_beat: observed 0x%0h expected none", s_out_data);
         end
         if (qs.size() != 0) begin
            e = qs.pop_front();
            s_pops++;
            chk("s_beat", 64'({s_out_sop, s_out_eop, s_out_data}), 64'(e));
         end
      end
      @(posedge clk);
      #1;
      if (c_perr) perr_c++;
      if (s_perr) perr_s++;
      if (int'(s_level) > max_s_level) max_s_level = int'(s_level);
   endtask

   task automatic send_c(input logic sop, input logic eop, input logic [DW-1:0] d);
      logic acc = 1'b0;
      c_in_valid = 1'b1; c_in_sop = sop; c_in_eop = eop; c_in_data = d;
      for (int i = 0; i < 64 && !acc; i++) begin
         acc = c_in_valid && c_in_ready;
         tick();
      end
      c_in_valid = 1'b0;
      chk("c_send_accepted", 64'(acc), 64'(1));
   endtask

   task automatic send_s(input logic sop, input logic eop, input logic [DW-1:0] d);
      logic acc = 1'b0;
      s_in_valid = 1'b1; s_in_sop = sop; s_in_eop = eop; s_in_data = d;
      for (int i = 0; i < 64 && !acc; i++) begin
         acc = s_in_valid && s_in_ready;
         tick();
      end
      s_in_valid = 1'b0;
      chk("s_send_accepted", 64'(acc), 64'(1));
   endtask

   task automatic drain_c();
      c_out_ready = 1'b1;
      for (int i = 0; i < 64 && (c_out_valid || qc.size() != 0); i++) tick();
      chk("c_drain_queue", 64'(qc.size()), 64'(0));
      chk("c_drain_level", 64'(c_level), 64'(0));
   endtask

   task automatic drain_s();
      s_out_ready = 1'b1;
      for (int i = 0; i < 64 && (s_out_valid || qs.size() != 0); i++) tick();
      chk("s_drain_queue", 64'(qs.size()), 64'(0));
      chk("s_drain_level", 64'(s_level), 64'(0));
   endtask

   initial begin
      int sent, pos, len, simul;
      logic acc, rd, reset_done;
      reset_n = 1'b0;
      c_in_valid = 1'b0; c_in_sop = 1'b0; c_in_eop = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_sop = 1'b0; s_in_eop = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(c_out_valid), 64'(0));
      chk("rst_level", 64'(c_level), 64'(0));
      chk("rst_pkt", 64'(c_pkt), 64'(0));
      chk("rst_in_ready", 64'(c_in_ready), 64'(0));
      chk("rst_perr", 64'(c_perr), 64'(0));
      chk("rst_sf_out_valid", 64'(s_out_valid), 64'(0));
      reset_n = 1'b1;
      tick();
      chk("post_rst_in_ready", 64'(c_in_ready), 64'(1));
      chk("post_rst_sf_in_ready", 64'(s_in_ready), 64'(1));

      // Cut-through 4-beat packet, one cycle latency
      c_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         c_in_valid = 1'b1; c_in_sop = (i == 0); c_in_eop = (i == 3);
         c_in_data = 32'(32'hA0 + i);
         tick();
         chk("t1_out_valid", 64'(c_out_valid), 64'(1));
         chk("t1_out_data", 64'(c_out_data), 64'(32'hA0 + i));
         chk("t1_level", 64'(c_level), 64'(1));
         chk("t1_perr", 64'(c_perr), 64'(0));
      end
      chk("t1_pkt_eop_stored", 64'(c_pkt), 64'(1));
      c_in_valid = 1'b0;
      tick();
      chk("t1_empty_valid", 64'(c_out_valid), 64'(0));
      chk("t1_empty_level", 64'(c_level), 64'(0));
      chk("t1_empty_pkt", 64'(c_pkt), 64'(0));

      // Fill to DEPTH with the output stalled
      c_out_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         c_in_valid = 1'b1; c_in_sop = (i == 0); c_in_eop = (i == 15);
         c_in_data = 32'(32'h100 + i);
         chk("t2_fill_ready", 64'(c_in_ready), 64'(1));
         tick();
      end
      chk("t2_full_level", 64'(c_level), 64'(16));
      chk("t2_full_in_ready", 64'(c_in_ready), 64'(0));
      chk("t2_full_pkt", 64'(c_pkt), 64'(1));
      c_in_sop = 1'b1; c_in_eop = 1'b1; c_in_data = 32'h200; c_out_ready = 1'b1;
      tick();
      chk("t2_freed_in_ready", 64'(c_in_ready), 64'(1));
      chk("t2_freed_level", 64'(c_level), 64'(15));
      c_out_ready = 1'b0;
      tick();
      c_in_valid = 1'b0;
      chk("t2_refill_level", 64'(c_level), 64'(16));
      chk("t2_refill_pkt", 64'(c_pkt), 64'(2));
      drain_c();

      // Store-and-forward holds until eop is stored
      s_out_ready = 1'b1;
      send_s(1'b1, 1'b0, 32'h1);
      chk("t3_hold_1", 64'(s_out_valid), 64'(0));
      send_s(1'b0, 1'b0, 32'h2);
      chk("t3_hold_2", 64'(s_out_valid), 64'(0));
      chk("t3_pkt_0", 64'(s_pkt), 64'(0));
      send_s(1'b0, 1'b1, 32'h3);
      chk("t3_release", 64'(s_out_valid), 64'(1));
      chk("t3_pkt_1", 64'(s_pkt), 64'(1));
      chk("t3_head", 64'(s_out_data), 64'(32'h1));
      tick();
      tick();
      chk("t3_pkt_still_1", 64'(s_pkt), 64'(1));
      tick();
      chk("t3_pkt_done", 64'(s_pkt), 64'(0));
      chk("t3_valid_done", 64'(s_out_valid), 64'(0));

      // Store-and-forward with a packet longer than DEPTH
      max_s_level = 0;
      s_pops = 0;
      for (int i = 0; i < 20; i++) send_s(i == 0, i == 19, 32'(32'h300 + i));
      drain_s();
      chk("t4_reached_full", 64'(max_s_level), 64'(16));
      chk("t4_beats_out", 64'(s_pops), 64'(20));

      // Framing violations
      c_out_ready = 1'b1;
      perr_c = 0;
      send_c(1'b1, 1'b0, 32'hB0);
      send_c(1'b1, 1'b0, 32'hB1);
      chk("t5_sop_sop_pulse", 64'(c_perr), 64'(1));
      send_c(1'b0, 1'b1, 32'hB2);
      tick(); tick();
      chk("t5_sop_sop_count", 64'(perr_c), 64'(1));
      perr_c = 0;
      send_c(1'b0, 1'b0, 32'hC0);
      tick(); tick();
      chk("t5_outside_count", 64'(perr_c), 64'(1));
      perr_c = 0;
      send_c(1'b1, 1'b1, 32'hD0);
      tick(); tick();
      chk("t5_single_count", 64'(perr_c), 64'(0));
      drain_c();

      // Random valid/ready, framed packets of 1-24 beats, mid-stream reset
      perr_c = 0; sent = 0; pos = 0; len = $urandom_range(1, 24); simul = 0;
      reset_done = 1'b0;
      for (int cyc = 0; cyc < 20000 && sent < 1000; cyc++) begin
         c_out_ready = 1'($urandom_range(0, 1));
         c_in_valid  = 1'($urandom_range(0, 1));
         c_in_sop    = (pos == 0);
         c_in_eop    = (pos == len - 1);
         c_in_data   = $urandom();
         acc = c_in_valid && c_in_ready;
         rd  = c_out_valid && c_out_ready;
         tick();
         if (acc && rd) simul++;
         chk("rnd_level", 64'(c_level), 64'(qc.size()));
         chk("rnd_pkt", 64'(c_pkt), 64'(eop_count()));
         if (acc) begin
            sent++;
            pos++;
            if (pos == len) begin
               pos = 0;
               len = $urandom_range(1, 24);
            end
         end
         if (sent == 500 && !reset_done) begin
            reset_n = 1'b0;
            #1;
            chk("rnd_rst_valid", 64'(c_out_valid), 64'(0));
            chk("rnd_rst_level", 64'(c_level), 64'(0));
            chk("rnd_rst_pkt", 64'(c_pkt), 64'(0));
            qc.delete();
            qs.delete();
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            pos = 0;
            len = $urandom_range(1, 24);
            reset_done = 1'b1;
         end
      end
      c_in_valid = 1'b0;
      chk("rnd_all_sent", 64'(sent), 64'(1000));
      chk("rnd_simul_seen", 64'(simul > 0), 64'(1));
      drain_c();
      chk("rnd_no_perr", 64'(perr_c), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
